// File: rtl/mm_pkg.sv
// Shared definitions for the mm datapath: vector geometry, adder latency and common types.
package mm_pkg;

  localparam int unsigned VEC_W        = 512;
  localparam int unsigned FP_W         = 32;
  localparam int unsigned VEC_LANES    = VEC_W / FP_W;
  localparam int unsigned VADD_LATENCY = 12;

  typedef logic [VEC_W-1:0] vec_t;

  typedef enum logic [0:0] {
    StFlush,
    StRun
  } buf_state_e;

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead FIFO; head entry is readable combinationally, zero when empty.
module result_fifo #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
      else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/vector_add_result_buffer.sv
// Catches the no-backpressure vector_add result stream in a FIFO and meters issue credits
// so every in-flight result is guaranteed a slot.
module vector_add_result_buffer
  import mm_pkg::*;
#(
  parameter int unsigned DATA_W      = VEC_W,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADD_LATENCY = VADD_LATENCY,
  parameter int unsigned CNT_W       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  inflight,
  output logic              err_overflow,
  output logic              err_spurious
);

  localparam int unsigned FLUSH_W = $clog2(ADD_LATENCY + 2);

  buf_state_e        state_q, state_d;
  logic [FLUSH_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic              err_overflow_q, err_spurious_q;
  logic              run, issue_fire, res_accept, pop_fire, fifo_full, fifo_empty;
  logic [CNT_W:0]    used;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFlush;
      flush_cnt_q <= FLUSH_W'(ADD_LATENCY);
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Stale results from the un-reset adder pipeline drain during the flush window.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      StFlush: begin
        if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - FLUSH_W'(1);
        if (flush_cnt_q <= FLUSH_W'(1)) state_d = StRun;
      end
      StRun: state_d = StRun;
    endcase
  end

  assign run         = (state_q == StRun);
  assign used        = {1'b0, occupancy} + {1'b0, inflight_q};
  assign issue_ready = run && (used < (CNT_W + 1)'(DEPTH));
  assign issue_fire  = issue_valid && issue_ready;
  assign res_accept  = res_valid && run;
  assign m_valid     = !fifo_empty;
  assign pop_fire    = m_valid && m_ready;

  always_comb begin
    inflight_d = inflight_q;
    if (issue_fire && !res_accept) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (res_accept && !issue_fire && inflight_q != '0) begin
      inflight_d = inflight_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q     <= '0;
      err_overflow_q <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      if (res_accept && fifo_full && !pop_fire) err_overflow_q <= 1'b1;
      if (res_accept && inflight_q == '0)       err_spurious_q <= 1'b1;
    end
  end

  result_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (res_accept),
    .push_data(res_data),
    .pop      (pop_fire),
    .pop_data (m_data),
    .count    (occupancy),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign inflight     = inflight_q;
  assign err_overflow = err_overflow_q;
  assign err_spurious = err_spurious_q;

endmodule

// File: doc/vector_add_result_buffer.md
Name: vector_add_result_buffer

Overview:
- Receiving end of the `vector_add` result stream (`vector_output_valid` / `vector`). That stream is a fixed-latency pipeline with no backpressure.
- Catches every result in a FIFO and presents it downstream over valid/ready.
- Issues credits to the upstream issuer so a result never arrives with no free slot.
- Sits between `vector_add` and the write-back / aggregation stage of the mm datapath.

Parameters:
- DATA_W, 512, result vector width (16 x fp32).
- DEPTH, 16, FIFO entries; power of two, >= 2.
- ADD_LATENCY, 12, `vector_add` input-valid-to-output-valid latency in cycles; sets the post-reset flush window.
- CNT_W, $clog2(DEPTH)+1, width of occupancy/credit counters.

Ports:
- clk, input, 1, block clock, shared with `vector_add`.
- rst_n, input, 1, asynchronous active-low reset.
- issue_valid, input, 1, upstream is driving `vector_input_valid` high this cycle (one add issued).
- issue_ready, output, 1, a credit is available; upstream may assert issue_valid only while high.
- res_valid, input, 1, from `vector_add` `vector_output_valid`.
- res_data, input, DATA_W, from `vector_add` `vector`.
- m_valid, output, 1, downstream result valid.
- m_ready, input, 1, downstream accept.
- m_data, output, DATA_W, head-of-FIFO result.
- occupancy, output, CNT_W, entries currently stored.
- inflight, output, CNT_W, issued adds not yet returned.
- err_overflow, output, 1, sticky: a result was dropped because the FIFO was full.
- err_spurious, output, 1, sticky: res_valid arrived with inflight==0 outside the flush window.

Behaviour:
- Reset (rst_n low, asynchronous):
  - occupancy=0, inflight=0, rd/wr pointers=0.
  - m_valid=0, m_data=0, issue_ready=0, err_*=0.
  - flush counter loaded with ADD_LATENCY.
- Flush window:
  - Lasts ADD_LATENCY cycles after rst_n deasserts; the counter decrements each cycle to 0.
  - During the window, issue_ready=0 and res_valid is ignored: not written, no error, inflight unchanged. This drops stale results from the un-reset adder pipeline.
- States: FLUSH (counter != 0) -> RUN (counter == 0). There is no return to FLUSH except via reset.
- Credit rule in RUN: issue_ready = (occupancy + inflight) < DEPTH, computed combinationally from registered counters.
- Issue accounting:
  - Issue fire = issue_valid && issue_ready.
  - issue_valid while issue_ready=0 has no effect on the counters.
- Push: occurs when res_valid is high in RUN. res_data is written at wr_ptr; wr_ptr and occupancy increment.
- Return accounting: each accepted res_valid in RUN decrements inflight.
  - Simultaneous issue fire and res_valid leaves inflight unchanged.
  - res_valid with inflight==0 sets err_spurious; the data is still stored if space exists, and inflight stays 0 (no underflow).
- Pop:
  - m_valid = (occupancy != 0).
  - m_data = entry at rd_ptr (show-ahead; storage may be a register array or LUTRAM with async read).
  - Pop fire = m_valid && m_ready; rd_ptr increments and occupancy decrements.
- Simultaneous push and pop: occupancy unchanged, both pointers advance. This is allowed when occupancy==DEPTH, because the pop frees the slot in the same cycle.
- Full push: push with occupancy==DEPTH and no pop drops the data and sets err_overflow. Pointers and occupancy are unchanged; inflight still decrements.
- Pointers: log2(DEPTH) bits, wrap naturally from DEPTH-1 to 0.
- Latency:
  - A result pushed in cycle t is visible on m_valid/m_data in cycle t+1.
  - Credit freed by a pop in cycle t is visible on issue_ready in cycle t+1.
- Sticky errors clear only on reset.
- m_data holds its value while m_valid && !m_ready.

Decomposition:
- Shared package mm_pkg:
  - VEC_W=512, FP_W=32, VEC_LANES=16.
  - VADD_LATENCY constant, used as the default ADD_LATENCY and by `vector_add` users.
  - typedef logic [VEC_W-1:0] vec_t.
- One sub-module: result_fifo, a plain synchronous show-ahead FIFO (push, pop, data, count, full, empty).
- vector_add_result_buffer owns the flush FSM, credit counter and error flags.

Test Plan:
- Reset release, res_valid=1 with data 0xDEAD... for cycles 1..12 -> nothing stored, occupancy=0, err_spurious=0, issue_ready rises at cycle 13.
- Issue 3 adds, adder model returns values 1.0/2.0/3.0 after 12 cycles, m_ready=1 -> m_data 0x3F800000/0x40000000/0x40400000 in lane 0, in order, each one cycle after return; inflight returns to 0.
- m_ready=0, issue continuously -> issue_ready falls after 16 fires, occupancy reaches 16, no err_overflow; release m_ready -> 16 results drained in order, pointers wrap to 0.
- occupancy=16 with forced res_valid and m_ready=1 in the same cycle -> occupancy stays 16, no drop. Repeat with m_ready=0 -> err_overflow=1, head data unchanged.
- res_valid with inflight=0 in RUN -> err_spurious=1 sticky, entry stored, inflight stays 0.
- Assert rst_n low mid-stream with occupancy=5, inflight=4 -> all outputs zero immediately. The 4 late results arriving within 12 cycles after release are discarded, with no errors.
